// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, defaults and character-size helper
package uart_pkg;
    localparam int DEFAULT_DIV_WIDTH = 16;
    localparam logic [1:0] CS_5 = 2'b00;
    localparam logic [1:0] CS_6 = 2'b01;
    localparam logic [1:0] CS_7 = 2'b10;
    localparam logic [1:0] CS_8 = 2'b11;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
    function automatic logic [7:0] char_mask(input logic [1:0] cs);
        return cs == CS_5 ? 8'h1F : cs == CS_6 ? 8'h3F : cs == CS_7 ? 8'h7F : 8'hFF;
    endfunction
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: line configuration and transmit handshake between register file and transmitter
interface uart_transmitter_if #(parameter int DIV_WIDTH = uart_pkg::DEFAULT_DIV_WIDTH);
    logic [DIV_WIDTH-1:0] baudDivisor;
    logic [1:0]           charSize;
    logic                 parityEnable;
    logic                 parityOdd;
    logic                 twoStopBits;
    logic [7:0]           txData;
    logic                 txValid;
    logic                 txReady;
    logic                 txd;
    logic                 busy;
    logic                 txDone;
    modport master (
        output baudDivisor, charSize, parityEnable, parityOdd, twoStopBits, txData, txValid,
        input  txReady, txd, busy, txDone
    );
    modport slave (
        input  baudDivisor, charSize, parityEnable, parityOdd, twoStopBits, txData, txValid,
        output txReady, txd, busy, txDone
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: end-of-bit tick every max(divisor,1) enabled cycles, restartable
module baud_tick_gen #(parameter int DIV_WIDTH = uart_pkg::DEFAULT_DIV_WIDTH) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 restart,
    input  logic                 enable,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_last;
    // a divisor of 0 behaves as 1, so the last count is 0 in both cases
    assign w_last = divisor == '0 ? '0 : divisor - 1'b1;
    assign tick = enable && !restart && r_cnt == w_last;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= (restart || !enable || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises accepted characters into start/data/parity/stop frames on txd
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input logic              clock_50MHz,
    input logic              reset_n,
    uart_transmitter_if.slave bus
);
    tx_state_t            r_state;
    logic [7:0]           r_shift;
    logic [2:0]           r_last;
    logic [2:0]           r_bit;
    logic                 r_par_en;
    logic                 r_par;
    logic                 r_two;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_txd;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_tick;
    logic                 w_accept;
    logic [7:0]           w_data;
    assign w_accept = r_state == IDLE && bus.txValid;
    assign w_data   = bus.txData & char_mask(bus.charSize);
    assign bus.txd     = r_txd;
    assign bus.txReady = r_ready;
    assign bus.busy    = r_busy;
    assign bus.txDone  = r_done;
    baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk     (clock_50MHz),
        .rst_n   (reset_n),
        .divisor (r_div),
        .restart (w_accept),
        .enable  (r_busy),
        .tick    (w_tick)
    );
    always_ff @(posedge clock_50MHz or negedge reset_n)
        if (!reset_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_last   <= '0;
            r_bit    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_two    <= 1'b0;
            r_div    <= '0;
            r_txd    <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state  <= START;
                    r_txd    <= 1'b0;
                    r_ready  <= 1'b0;
                    r_busy   <= 1'b1;
                    r_shift  <= w_data;
                    r_last   <= {1'b1, bus.charSize};
                    r_bit    <= '0;
                    r_par_en <= bus.parityEnable;
                    r_par    <= ^w_data ^ bus.parityOdd;
                    r_two    <= bus.twoStopBits;
                    r_div    <= bus.baudDivisor;
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_txd   <= r_shift[0];
                end
                DATA: if (w_tick) begin
                    if (r_bit == r_last) begin
                        r_state <= r_par_en ? PARITY : STOP;
                        r_txd   <= r_par_en ? r_par : 1'b1;
                        r_bit   <= '0;
                    end else begin
                        r_shift <= r_shift >> 1;
                        r_txd   <= r_shift[1];
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                PARITY: if (w_tick) begin
                    r_state <= STOP;
                    r_txd   <= 1'b1;
                end
                STOP: if (w_tick) begin
                    // the bit counter marks that the first of two stop bits is done
                    if (r_two && r_bit == 3'd0) r_bit <= 3'd1;
                    else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench comparing txd/handshake against a per-cycle frame model
module tb_uart_transmitter;
    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   done_cnt = 0;
    logic done_next = 1'b0;
    exp_t exp_q[$];

    uart_transmitter_if #(.DIV_WIDTH(16)) bus ();
    uart_transmitter #(.DIV_WIDTH(16)) dut (
        .clock_50MHz (clk),
        .reset_n     (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic push_frame(input logic [7:0] data, input logic [1:0] cs, input logic pe,
                              input logic odd, input logic two, input logic [15:0] div);
        logic bits[$];
        logic p;
        int   d;
        int   n;
        d = (div == 16'd0) ? 1 : int'(div);
        n = 5 + int'(cs);
        p = odd;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(data[i]);
            p = p ^ data[i];
        end
        if (pe) bits.push_back(p);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < d; k++)
                exp_q.push_back('{b: bits[i], last: (i == bits.size() - 1 && k == d - 1)});
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                done_next = 1'b0;
            end else begin
                checks++;
                if (done_next) begin
                    if (bus.txd !== 1'b1 || bus.txDone !== 1'b1 || bus.txReady !== 1'b1 || bus.busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done_cycle t=%0t got txd=%b done=%b rdy=%b busy=%b, expected 1 1 1 0",
                                 $time, bus.txd, bus.txDone, bus.txReady, bus.busy);
                    end
                    done_next = 1'b0;
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (bus.txd !== e.b || bus.txDone !== 1'b0 || bus.txReady !== 1'b0 || bus.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_bit t=%0t got txd=%b done=%b rdy=%b busy=%b, expected %b 0 0 1",
                                 $time, bus.txd, bus.txDone, bus.txReady, bus.busy, e.b);
                    end
                    done_next = e.last;
                end else if (bus.txd !== 1'b1 || bus.txDone !== 1'b0 || bus.txReady !== 1'b1 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_line t=%0t got txd=%b done=%b rdy=%b busy=%b, expected 1 0 1 0",
                             $time, bus.txd, bus.txDone, bus.txReady, bus.busy);
                end
                if (bus.txDone === 1'b1) done_cnt++;
                if (bus.txValid && bus.txReady === 1'b1)
                    push_frame(bus.txData, bus.charSize, bus.parityEnable, bus.parityOdd, bus.twoStopBits, bus.baudDivisor);
            end
        end
    endtask

    task automatic set_cfg(input logic [7:0] data, input logic [1:0] cs, input logic pe,
                           input logic odd, input logic two, input logic [15:0] div);
        bus.txData       = data;
        bus.charSize     = cs;
        bus.parityEnable = pe;
        bus.parityOdd    = odd;
        bus.twoStopBits  = two;
        bus.baudDivisor  = div;
    endtask

    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = bus.txReady === 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout got txReady=%b, expected 1 within 500 cycles", bus.txReady);
        end
        t0 = cyc;
    endtask

    // returns one cycle after acceptance with config scrambled to prove it was captured
    task automatic send(input logic [7:0] data, input logic [1:0] cs, input logic pe,
                        input logic odd, input logic two, input logic [15:0] div);
        @(posedge clk);
        #1;
        set_cfg(data, cs, pe, odd, two, div);
        bus.txValid = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        bus.txValid = 1'b0;
        set_cfg(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(1, 9)));
    endtask

    task automatic wait_done(output int len);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = bus.txDone === 1'b1;
        end
        len = seen ? cyc - t0 : -1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.txd !== 1'b1 || bus.txReady !== 1'b1 || bus.busy !== 1'b0 || bus.txDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got txd=%b rdy=%b busy=%b done=%b, expected 1 1 0 0",
                     bus.txd, bus.txReady, bus.busy, bus.txDone);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.txd !== 1'b1 || bus.txReady !== 1'b1 || bus.busy !== 1'b0 || bus.txDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got txd=%b rdy=%b busy=%b done=%b, expected 1 1 0 0",
                     bus.txd, bus.txReady, bus.busy, bus.txDone);
        end
    endtask

    task automatic test_8n1();
        int len;
        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 16'd4);
        @(negedge clk);
        checks++;
        if (bus.txd !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_start got txd=%b, expected 0", bus.txd);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.txd !== 1'b1) begin
            errors++;
            $display("FAIL 8n1_bit0 got txd=%b, expected 1", bus.txd);
        end
        wait_done(len);
        checks++;
        if (len !== 41) begin
            errors++;
            $display("FAIL 8n1_done_cycle got %0d, expected 41", len);
        end
    endtask

    task automatic test_parity();
        int len;
        for (int odd = 0; odd < 2; odd++) begin
            send(8'h07, 2'b11, 1'b1, 1'(odd), 1'b0, 16'd2);
            repeat (19) @(negedge clk);
            checks++;
            if (bus.txd !== 1'(1 - odd)) begin
                errors++;
                $display("FAIL parity_bit odd=%0d got txd=%b, expected %0d", odd, bus.txd, 1 - odd);
            end
            wait_done(len);
            checks++;
            if (len !== 23) begin
                errors++;
                $display("FAIL parity_len odd=%0d got %0d, expected 23", odd, len);
            end
        end
    endtask

    task automatic test_5bit_2stop();
        int len;
        send(8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 16'd3);
        wait_done(len);
        checks++;
        if (len !== 25) begin
            errors++;
            $display("FAIL 5n2_len got %0d, expected 25", len);
        end
    endtask

    task automatic test_baud_zero();
        int len;
        send(8'h3A, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0);
        wait_done(len);
        checks++;
        if (len !== 11) begin
            errors++;
            $display("FAIL baud0_len got %0d, expected 11", len);
        end
    endtask

    task automatic test_back_to_back();
        int   len;
        int   rdy_n;
        int   done_c;
        int   acc_c;
        logic hit;
        @(posedge clk);
        #1;
        set_cfg(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 16'd3);
        bus.txValid = 1'b1;
        wait_accept();
        @(posedge clk);
        #1 bus.txData = 8'h3C;
        rdy_n = 0;
        done_c = -1;
        acc_c = -2;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (bus.txReady === 1'b1) rdy_n++;
            if (bus.txDone === 1'b1) done_c = cyc;
            if (bus.txReady === 1'b1) begin
                acc_c = cyc;
                hit = 1'b1;
            end
        end
        checks++;
        if (acc_c !== done_c || rdy_n !== 1) begin
            errors++;
            $display("FAIL b2b_gap got accept_cyc=%0d done_cyc=%0d ready_cycles=%0d, expected equal cycles and 1",
                     acc_c, done_c, rdy_n);
        end
        t0 = cyc;
        @(posedge clk);
        #1 bus.txValid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.txd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start got txd=%b, expected 0", bus.txd);
        end
        wait_done(len);
        checks++;
        if (len !== 31) begin
            errors++;
            $display("FAIL b2b_len got %0d, expected 31", len);
        end
    endtask

    task automatic test_reset_mid();
        int len;
        int d0;
        send(8'hC3, 2'b11, 1'b1, 1'b0, 1'b1, 16'd4);
        repeat (12) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.txReady !== 1'b1 || bus.txDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got txd=%b busy=%b rdy=%b done=%b, expected 1 0 1 0",
                     bus.txd, bus.busy, bus.txReady, bus.txDone);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL reset_no_done got %0d txDone pulses, expected 0", done_cnt - d0);
        end
        send(8'h96, 2'b11, 1'b1, 1'b1, 1'b0, 16'd2);
        wait_done(len);
        checks++;
        if (len !== 23) begin
            errors++;
            $display("FAIL post_reset_len got %0d, expected 23", len);
        end
    endtask

    initial begin
        bus.txValid = 1'b0;
        set_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 16'd1);
        fork
            monitor();
        join_none
        test_reset();
        test_8n1();
        test_parity();
        test_5bit_2stop();
        test_baud_zero();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
